dtree_seq_eval: RTL

- Parametrised, programmable successor to the team's fixed combinational decision-tree classifiers.
- Walks a register-resident node table one comparison per cycle instead of unrolling the tree in logic; trades latency for area on printed targets.
- Sits between the sensor feature register bank (upstream, valid/ready) and the class consumer (downstream, valid/ready).
- The node table is written over a simple config port, so one netlist serves any trained tree up to N_NODES nodes.

---
 rtl/dtree_seq_pkg.sv | 74 +++++++
 rtl/dtree_seq_eval_if.sv | 41 ++++
 rtl/dtree_node_cmp.sv | 61 ++++++
 rtl/dtree_seq_eval.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/dtree_seq_pkg.sv
// Shared types and sizing helpers for the sequential decision-tree evaluator.
// Holds the FSM state enum, field-width functions, the default-configuration
// node_t layout and the bit offsets of each node-word field (LSB-relative).
// Node word, MSB..LSB: is_leaf | feat | prec | thr | left | right.
package dtree_seq_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_DONE} state_e;

    localparam int DEF_N_FEAT    = 6;
    localparam int DEF_FEAT_W    = 8;
    localparam int DEF_CLASS_W   = 2;
    localparam int DEF_N_NODES   = 64;
    localparam int DEF_MAX_DEPTH = 15;

    function automatic int fidx_w(input int n_feat);
        return (n_feat > 1) ? $clog2(n_feat) : 1;
    endfunction

    function automatic int prec_w(input int feat_w);
        return $clog2(feat_w + 1);
    endfunction

    function automatic int node_aw(input int n_nodes);
        return (n_nodes > 1) ? $clog2(n_nodes) : 1;
    endfunction

    function automatic int depth_w(input int max_depth);
        return (max_depth > 0) ? $clog2(max_depth + 1) : 1;
    endfunction

    function automatic int node_w(input int n_feat, input int feat_w, input int n_nodes);
        return 1 + fidx_w(n_feat) + prec_w(feat_w) + feat_w + 2 * node_aw(n_nodes);
    endfunction

    // Field offsets within a node word.
    function automatic int off_left(input int n_nodes);
        return node_aw(n_nodes);
    endfunction
    function automatic int off_thr(input int n_nodes);
        return 2 * node_aw(n_nodes);
    endfunction
    function automatic int off_prec(input int feat_w, input int n_nodes);
        return off_thr(n_nodes) + feat_w;
    endfunction
    function automatic int off_feat(input int feat_w, input int n_nodes);
        return off_prec(feat_w, n_nodes) + prec_w(feat_w);
    endfunction
    function automatic int off_leaf(input int n_feat, input int feat_w, input int n_nodes);
        return off_feat(feat_w, n_nodes) + fidx_w(n_feat);
    endfunction

    localparam int DEF_FIDX_W   = fidx_w(DEF_N_FEAT);
    localparam int DEF_PREC_W   = prec_w(DEF_FEAT_W);
    localparam int DEF_NODE_AW  = node_aw(DEF_N_NODES);
    localparam int DEF_NODE_W   = node_w(DEF_N_FEAT, DEF_FEAT_W, DEF_N_NODES);
    localparam int DEF_DEPTH_W  = depth_w(DEF_MAX_DEPTH);

    localparam int DEF_OFF_RIGHT = 0;
    localparam int DEF_OFF_LEFT  = off_left(DEF_N_NODES);
    localparam int DEF_OFF_THR   = off_thr(DEF_N_NODES);
    localparam int DEF_OFF_PREC  = off_prec(DEF_FEAT_W, DEF_N_NODES);
    localparam int DEF_OFF_FEAT  = off_feat(DEF_FEAT_W, DEF_N_NODES);
    localparam int DEF_OFF_LEAF  = off_leaf(DEF_N_FEAT, DEF_FEAT_W, DEF_N_NODES);

    typedef struct packed {
        logic                   is_leaf;
        logic [DEF_FIDX_W-1:0]  feat;
        logic [DEF_PREC_W-1:0]  prec;
        logic [DEF_FEAT_W-1:0]  thr;
        logic [DEF_NODE_AW-1:0] left;
        logic [DEF_NODE_AW-1:0] right;
    } node_t;

endpackage

// File: rtl/dtree_seq_eval_if.sv
// Bundle of the evaluator's handshake and config signals.
//   in_valid/in_ready/in_feat   : feature vector from the sensor bank
//   out_valid/out_ready/out_class/out_err : result to the class consumer
//   cfg_we/cfg_addr/cfg_data    : node-table write port
//   out_depth                   : comparison count (only with DTREE_SEQ_DEPTH_EN)
// Modports: master = producer/consumer/config side, slave = evaluator.
interface dtree_seq_eval_if #(
    parameter int N_FEAT  = dtree_seq_pkg::DEF_N_FEAT,
    parameter int FEAT_W  = dtree_seq_pkg::DEF_FEAT_W,
    parameter int CLASS_W = dtree_seq_pkg::DEF_CLASS_W,
    parameter int N_NODES = dtree_seq_pkg::DEF_N_NODES
);
    localparam int NODE_AW = dtree_seq_pkg::node_aw(N_NODES);
    localparam int NODE_W  = dtree_seq_pkg::node_w(N_FEAT, FEAT_W, N_NODES);

    logic                     in_valid;
    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] in_feat;
    logic                     out_valid;
    logic                     out_ready;
    logic [CLASS_W-1:0]       out_class;
    logic                     out_err;
    logic                     cfg_we;
    logic [NODE_AW-1:0]       cfg_addr;
    logic [NODE_W-1:0]        cfg_data;

`ifdef DTREE_SEQ_DEPTH_EN
    logic [dtree_seq_pkg::DEF_DEPTH_W-1:0] out_depth;

    modport master (output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
                    input  in_ready, out_valid, out_class, out_err, out_depth);
    modport slave  (input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
                    output in_ready, out_valid, out_class, out_err, out_depth);
`else
    modport master (output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
                    input  in_ready, out_valid, out_class, out_err);
    modport slave  (input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_data,
                    output in_ready, out_valid, out_class, out_err);
`endif

endinterface

// File: rtl/dtree_node_cmp.sv
// Combinational evaluation of one node against the captured feature vector.
//   feat_i  : packed features, feature i at [i*FEAT_W +: FEAT_W]
//   node_i  : node word
//   next_o  : chosen child (out-of-range children fold to node 0)
//   leaf_o  : node is a leaf
//   class_o : leaf class (thr LSBs)
module dtree_node_cmp
    import dtree_seq_pkg::*;
#(
    parameter  int N_FEAT  = DEF_N_FEAT,
    parameter  int FEAT_W  = DEF_FEAT_W,
    parameter  int CLASS_W = DEF_CLASS_W,
    parameter  int N_NODES = DEF_N_NODES,
    localparam int NODE_AW = node_aw(N_NODES),
    localparam int NODE_W  = node_w(N_FEAT, FEAT_W, N_NODES)
) (
    input  logic [N_FEAT*FEAT_W-1:0] feat_i,
    input  logic [NODE_W-1:0]        node_i,
    output logic [NODE_AW-1:0]       next_o,
    output logic                     leaf_o,
    output logic [CLASS_W-1:0]       class_o
);
    localparam int FIDX_W = fidx_w(N_FEAT);
    localparam int PREC_W = prec_w(FEAT_W);

    logic [FIDX_W-1:0]  fidx;
    logic [PREC_W-1:0]  prec;
    logic [FEAT_W-1:0]  thr;
    logic [NODE_AW-1:0] left, right, child;
    logic [FEAT_W-1:0]  fval, key;
    logic [PREC_W-1:0]  prec_c;

    assign right  = node_i[0 +: NODE_AW];
    assign left   = node_i[off_left(N_NODES) +: NODE_AW];
    assign thr    = node_i[off_thr(N_NODES) +: FEAT_W];
    assign prec   = node_i[off_prec(FEAT_W, N_NODES) +: PREC_W];
    assign fidx   = node_i[off_feat(FEAT_W, N_NODES) +: FIDX_W];
    assign leaf_o = node_i[off_leaf(N_FEAT, FEAT_W, N_NODES)];
    assign class_o = thr[CLASS_W-1:0];

    always_comb begin
        // Unmatched feature index (>= N_FEAT) leaves fval at 0.
        fval = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (fidx == FIDX_W'(i)) fval = feat_i[i*FEAT_W +: FEAT_W];
        end
        prec_c = (prec > PREC_W'(FEAT_W)) ? PREC_W'(FEAT_W) : prec;
        // prec 0 shifts by the full width, so key is 0 and the walk goes left.
        key   = fval >> (PREC_W'(FEAT_W) - prec_c);
        child = (key <= thr) ? left : right;
    end

    generate
        if (N_NODES < (1 << NODE_AW)) begin : g_fold
            assign next_o = (child < NODE_AW'(N_NODES)) ? child : '0;
        end else begin : g_full
            assign next_o = child;
        end
    endgenerate

endmodule

// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree classifier: walks a programmable node table one
// node per cycle. IDLE accepts a vector, WALK evaluates nodes, DONE holds the
// result until the consumer takes it. Table writes only land in IDLE when no
// vector is being accepted, so a walk always sees a frozen table.
//   clk, rst_n : clock, async active-low reset
//   bus        : dtree_seq_eval_if.slave (input, output and config channels)
// Optional: define DTREE_SEQ_DEPTH_EN to add bus.out_depth (comparison count).
module dtree_seq_eval
    import dtree_seq_pkg::*;
#(
    parameter  int N_FEAT    = DEF_N_FEAT,
    parameter  int FEAT_W    = DEF_FEAT_W,
    parameter  int CLASS_W   = DEF_CLASS_W,
    parameter  int N_NODES   = DEF_N_NODES,
    parameter  int MAX_DEPTH = DEF_MAX_DEPTH,
    localparam int NODE_AW   = node_aw(N_NODES),
    localparam int NODE_W    = node_w(N_FEAT, FEAT_W, N_NODES),
    localparam int DEPTH_W   = depth_w(MAX_DEPTH)
) (
    input logic            clk,
    input logic            rst_n,
    dtree_seq_eval_if.slave bus
);
    state_e                   state_q, state_d;
    logic [NODE_AW-1:0]       node_q, node_d;
    logic [DEPTH_W-1:0]       step_q, step_d;
    logic [N_FEAT*FEAT_W-1:0] feat_q, feat_d;
    logic [CLASS_W-1:0]       class_q, class_d;
    logic                     err_q, err_d;
`ifdef DTREE_SEQ_DEPTH_EN
    logic [DEPTH_W-1:0]       depth_q, depth_d;
`endif

    logic [NODE_W-1:0]  tbl_q [N_NODES];
    logic [NODE_AW-1:0] nxt_node;
    logic               is_leaf;
    logic [CLASS_W-1:0] leaf_cls;
    logic               accept, addr_ok, tbl_we;

    dtree_node_cmp #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W),
        .CLASS_W(CLASS_W),
        .N_NODES(N_NODES)
    ) u_cmp (
        .feat_i (feat_q),
        .node_i (tbl_q[node_q]),
        .next_o (nxt_node),
        .leaf_o (is_leaf),
        .class_o(leaf_cls)
    );

    assign accept = (state_q == ST_IDLE) && bus.in_valid;

    generate
        if (N_NODES < (1 << NODE_AW)) begin : g_addr_chk
            assign addr_ok = (bus.cfg_addr < NODE_AW'(N_NODES));
        end else begin : g_addr_all
            assign addr_ok = 1'b1;
        end
    endgenerate

    // An input accept in the same cycle wins over a table write.
    assign tbl_we = bus.cfg_we && (state_q == ST_IDLE) && !bus.in_valid && addr_ok;

    always_comb begin
        state_d = state_q;
        node_d  = node_q;
        step_d  = step_q;
        feat_d  = feat_q;
        class_d = class_q;
        err_d   = err_q;
`ifdef DTREE_SEQ_DEPTH_EN
        depth_d = depth_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    feat_d  = bus.in_feat;
                    node_d  = '0;
                    step_d  = '0;
                    state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                if (is_leaf) begin
                    class_d = leaf_cls;
                    err_d   = 1'b0;
`ifdef DTREE_SEQ_DEPTH_EN
                    depth_d = step_q;
`endif
                    state_d = ST_DONE;
                end else if (step_q == DEPTH_W'(MAX_DEPTH)) begin
                    class_d = '0;
                    err_d   = 1'b1;
`ifdef DTREE_SEQ_DEPTH_EN
                    depth_d = step_q;
`endif
                    state_d = ST_DONE;
                end else begin
                    node_d = nxt_node;
                    step_d = step_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            node_q  <= '0;
            step_q  <= '0;
            feat_q  <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
`ifdef DTREE_SEQ_DEPTH_EN
            depth_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            step_q  <= step_d;
            feat_q  <= feat_d;
            class_q <= class_d;
            err_q   <= err_d;
`ifdef DTREE_SEQ_DEPTH_EN
            depth_q <= depth_d;
`endif
        end
    end

    // Table is deliberately unreset so a trained tree survives rst_n.
    always_ff @(posedge clk) begin
        if (tbl_we) tbl_q[bus.cfg_addr] <= bus.cfg_data;
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_class = class_q;
    assign bus.out_err   = err_q;
`ifdef DTREE_SEQ_DEPTH_EN
    assign bus.out_depth = depth_q;
`endif

endmodule
